// File: rtl/aes_pkg.sv
// Shared definitions for the serial front end of the AES cores:
// data widths, the slave port state encoding and the start-marker value.
package aes_pkg;

    localparam int MSG_W = 128;
    localparam int KEY_W = 128;
    // Bit counter width; 2**CNT_W must exceed MSG_W + KEY_W.
    localparam int CNT_W = 9;

    // Value driven on miso for the single cycle that precedes the result.
    localparam logic MARKER_BIT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_START,
        ST_WAIT,
        ST_MARK,
        ST_TX,
        ST_DONE
    } state_t;

endpackage

// File: rtl/spi_slave_port_if.sv
// Serial link plus core handshake seen by one spi_slave_port instance.
// The slave modport is the port block; master is the serial master and
// core side (used by whatever surrounds the block).
interface spi_slave_port_if
    import aes_pkg::*;
#(
    parameter int MSG_W = aes_pkg::MSG_W,
    parameter int KEY_W = aes_pkg::KEY_W
);

    logic             cs;
    logic             mosi;
    logic             miso;
    logic [MSG_W-1:0] core_msg;
    logic [KEY_W-1:0] core_key;
    logic             core_start;
    logic [MSG_W-1:0] core_result;
    logic             core_done;
    logic             busy;

    modport slave (
        input  cs,
        input  mosi,
        input  core_result,
        input  core_done,
        output miso,
        output core_msg,
        output core_key,
        output core_start,
        output busy
    );

    modport master (
        output cs,
        output mosi,
        output core_result,
        output core_done,
        input  miso,
        input  core_msg,
        input  core_key,
        input  core_start,
        input  busy
    );

endinterface

// File: rtl/spi_shift_reg.sv
// Parameterised shift register with parallel load. SHIFT_LEFT=1 moves data
// toward the MSB (serial_in enters at bit 0); SHIFT_LEFT=0 moves it toward
// the LSB (serial_in enters at bit W-1). Load has priority over shift.
module spi_shift_reg
    import aes_pkg::*;
#(
    parameter int W          = 8,
    parameter bit SHIFT_LEFT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         shift_en,
    input  logic         serial_in,
    output logic [W-1:0] q
);

    logic [W-1:0] data_reg;
    logic [W-1:0] data_next;
    logic [W-1:0] shifted;

    // Per-bit neighbour selection for the configured direction.
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        if (SHIFT_LEFT) begin : g_left
            if (gi == 0) begin : g_in
                assign shifted[gi] = serial_in;
            end else begin : g_mid
                assign shifted[gi] = data_reg[gi-1];
            end
        end else begin : g_right
            if (gi == W-1) begin : g_in
                assign shifted[gi] = serial_in;
            end else begin : g_mid
                assign shifted[gi] = data_reg[gi+1];
            end
        end
    end

    // Choose between hold, parallel load and one-bit shift.
    always_comb begin
        data_next = data_reg;
        if (load) begin
            data_next = load_data;
        end else if (shift_en) begin
            data_next = shifted;
        end
    end

    // Register stage with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg <= '0;
        end else begin
            data_reg <= data_next;
        end
    end

    assign q = data_reg;

endmodule

// File: rtl/spi_slave_port.sv
// Slave end of the serial link in front of an AES encrypt/decrypt core.
// Receives message then key MSB-first while cs is high, starts the core,
// waits for its done strobe, then returns a start marker followed by the
// result MSB-first on miso. Dropping cs before DONE abandons the transaction.
module spi_slave_port
    import aes_pkg::*;
#(
    parameter int MSG_W = aes_pkg::MSG_W,
    parameter int KEY_W = aes_pkg::KEY_W,
    parameter int CNT_W = aes_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    spi_slave_port_if.slave    bus
);

    localparam int RX_W = MSG_W + KEY_W;
    localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(RX_W - 1);
    localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(MSG_W - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             rx_shift;
    logic             tx_load;
    logic             tx_shift;
    logic [RX_W-1:0]  rx_q;
    logic [MSG_W-1:0] tx_q;
    logic [MSG_W-2:0] tx_unused;

    // Incoming frame: message occupies the upper half once all bits are in.
    spi_shift_reg #(.W(RX_W), .SHIFT_LEFT(1'b1)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .load      (1'b0),
        .load_data ({RX_W{1'b0}}),
        .shift_en  (rx_shift),
        .serial_in (bus.mosi),
        .q         (rx_q)
    );

    // Outgoing result: loaded on core_done, MSB presented on miso.
    spi_shift_reg #(.W(MSG_W), .SHIFT_LEFT(1'b1)) u_tx (
        .clk       (clk),
        .rst       (rst),
        .load      (tx_load),
        .load_data (bus.core_result),
        .shift_en  (tx_shift),
        .serial_in (1'b0),
        .q         (tx_q)
    );

    // Only the MSB leaves the block; the lower bits just feed the shifter.
    assign tx_unused = tx_q[MSG_W-2:0];

    // The receive register only shifts in IDLE/RX, so these hold steady from
    // the core_start pulse until the result is latched.
    assign bus.core_msg = rx_q[RX_W-1 -: MSG_W];
    assign bus.core_key = rx_q[KEY_W-1:0];

    // State and bit counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state, counter and shifter controls; cs low aborts any active state.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rx_shift   = 1'b0;
        tx_load    = 1'b0;
        tx_shift   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // The cs-rise cycle already carries bit 0.
                if (bus.cs) begin
                    rx_shift   = 1'b1;
                    cnt_next   = CNT_W'(1);
                    state_next = ST_RX;
                end
            end
            ST_RX: begin
                if (!bus.cs) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    rx_shift = 1'b1;
                    if (cnt_reg == RX_LAST) begin
                        cnt_next   = '0;
                        state_next = ST_START;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            ST_START: begin
                if (!bus.cs) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // An abort takes precedence over a simultaneous core_done.
                if (!bus.cs) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (bus.core_done) begin
                    tx_load    = 1'b1;
                    state_next = ST_MARK;
                end
            end
            ST_MARK: begin
                if (!bus.cs) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    state_next = ST_TX;
                end
            end
            ST_TX: begin
                if (!bus.cs) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    tx_shift = 1'b1;
                    if (cnt_reg == TX_LAST) begin
                        cnt_next   = '0;
                        state_next = ST_DONE;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                // Holding cs high parks here; a new frame needs a cs low.
                if (!bus.cs) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Serial output: marker, then result bits, otherwise idle low.
    always_comb begin
        bus.miso = 1'b0;
        case (state_reg)
            ST_MARK: bus.miso = MARKER_BIT;
            ST_TX:   bus.miso = tx_q[MSG_W-1];
            default: bus.miso = 1'b0;
        endcase
    end

    // A cs drop during START suppresses the start request.
    assign bus.core_start = (state_reg == ST_START) && bus.cs;
    assign bus.busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_spi_slave_port.sv
// Directed bench for spi_slave_port: a stub core answers core_start after a
// fixed latency, expected miso bits are queued when a frame is sent and
// popped as the result is shifted out.
module tb_spi_slave_port;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_slave_port_if bus ();

    spi_slave_port dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int starts      = 0;
    int start_cyc   = -1;
    int done_cyc    = -1;
    int stub_cnt    = 0;
    int stub_lat    = 12;
    int force_done_at = -1;
    bit stub_en     = 1'b1;
    logic [127:0] stub_res = '0;
    logic [127:0] seen_msg = '0;
    logic [127:0] seen_key = '0;
    logic exp_q[$];

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs just after the edge, observe 1 ns later.
    task automatic step(input logic cs_v, input logic mosi_v);
        @(posedge clk);
        #1;
        cyc++;
        bus.cs        = cs_v;
        bus.mosi      = mosi_v;
        bus.core_done = 1'b0;
        if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0) begin
                bus.core_done   = 1'b1;
                bus.core_result = stub_res;
            end
        end
        if (force_done_at == cyc) begin
            bus.core_done   = 1'b1;
            bus.core_result = stub_res;
        end
        #1;
        if (bus.core_start === 1'b1) begin
            starts++;
            start_cyc = cyc;
            seen_msg  = bus.core_msg;
            seen_key  = bus.core_key;
            if (stub_en) stub_cnt = stub_lat;
        end
        if (bus.core_done === 1'b1) done_cyc = cyc;
    endtask

    task automatic send_frame(input logic [127:0] msg, input logic [127:0] key);
        logic [255:0] frame;
        frame = {msg, key};
        for (int i = 0; i < 256; i++) step(1'b1, frame[255-i]);
    endtask

    // Full transaction; rst_bit >= 0 asserts reset during that TX bit.
    task automatic run_txn(input string name, input logic [127:0] msg, input logic [127:0] key,
                           input logic [127:0] res, input int hold, input int rst_bit);
        int s0;
        int last_bit_cyc;
        int bad;
        bit found;
        logic e;
        stub_res = res;
        stub_en  = 1'b1;
        s0       = starts;
        for (int i = 0; i < 128; i++) exp_q.push_back(res[127-i]);
        send_frame(msg, key);
        last_bit_cyc = cyc;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            step(1'b1, 1'($urandom));
            if (bus.miso === 1'b1) found = 1'b1;
        end
        chk($sformatf("%s marker_seen", name), 128'(found), 128'd1);
        chk($sformatf("%s start_count", name), 128'(starts - s0), 128'd1);
        chk($sformatf("%s start_cycle", name), 128'(start_cyc), 128'(last_bit_cyc + 1));
        chk($sformatf("%s core_msg", name), seen_msg, msg);
        chk($sformatf("%s core_key", name), seen_key, key);
        chk($sformatf("%s marker_cycle", name), 128'(cyc), 128'(done_cyc + 1));
        for (int i = 0; i < 128; i++) begin
            step(1'b1, 1'($urandom));
            e = exp_q.pop_front();
            chk($sformatf("%s tx_bit%0d", name, i), 128'(bus.miso), 128'(e));
            if (i == rst_bit) begin
                rst = 1'b1;
                #1;
                chk($sformatf("%s rst_miso", name), 128'(bus.miso), 128'd0);
                chk($sformatf("%s rst_busy", name), 128'(bus.busy), 128'd0);
                chk($sformatf("%s rst_start", name), 128'(bus.core_start), 128'd0);
                chk($sformatf("%s rst_core_msg", name), bus.core_msg, 128'd0);
                exp_q.delete();
                step(1'b0, 1'b0);
                step(1'b0, 1'b0);
                rst = 1'b0;
                step(1'b0, 1'b0);
                chk($sformatf("%s post_rst_busy", name), 128'(bus.busy), 128'd0);
                return;
            end
        end
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            step(1'b1, 1'($urandom));
            if (bus.miso !== 1'b0 || bus.busy !== 1'b1) bad++;
        end
        chk($sformatf("%s done_hold", name), 128'(bad), 128'd0);
        chk($sformatf("%s single_start", name), 128'(starts - s0), 128'd1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk($sformatf("%s idle_busy", name), 128'(bus.busy), 128'd0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int s0;
        int ones;
        bus.cs          = 1'b0;
        bus.mosi        = 1'b0;
        bus.core_done   = 1'b0;
        bus.core_result = '0;

        // Reset values.
        repeat (3) @(posedge clk);
        #2;
        chk("reset miso", 128'(bus.miso), 128'd0);
        chk("reset busy", 128'(bus.busy), 128'd0);
        chk("reset core_start", 128'(bus.core_start), 128'd0);
        chk("reset core_msg", bus.core_msg, 128'd0);
        chk("reset core_key", bus.core_key, 128'd0);
        rst = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        $display("txn reset: checked");

        // Encrypt direction with cs held high 50 cycles after DONE.
        run_txn("enc", PT, KEY, CT, 50, -1);
        $display("txn enc: msg=%h key=%h res=%h", PT, KEY, CT);

        // Decrypt direction.
        run_txn("dec", CT, KEY, PT, 5, -1);
        $display("txn dec: msg=%h key=%h res=%h", CT, KEY, PT);

        // Abort after 100 received bits.
        s0 = starts;
        for (int i = 0; i < 100; i++) step(1'b1, 1'($urandom));
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("rx_abort busy", 128'(bus.busy), 128'd0);
        chk("rx_abort miso", 128'(bus.miso), 128'd0);
        repeat (5) step(1'b0, 1'b0);
        chk("rx_abort no_start", 128'(starts - s0), 128'd0);
        $display("txn rx_abort: cs dropped after 100 bits");
        run_txn("post_rx_abort", rnd128(), rnd128(), rnd128(), 3, -1);
        $display("txn post_rx_abort: complete");

        // Abort while waiting for the core; late core_done must be dropped.
        stub_en  = 1'b0;
        stub_res = rnd128();
        send_frame(rnd128(), rnd128());
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        force_done_at = cyc + 5;
        ones = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0);
            if (bus.miso !== 1'b0) ones++;
        end
        force_done_at = -1;
        chk("wait_abort no_marker", 128'(ones), 128'd0);
        chk("wait_abort busy", 128'(bus.busy), 128'd0);
        stub_en = 1'b1;
        $display("txn wait_abort: late core_done applied");
        run_txn("post_wait_abort", rnd128(), rnd128(), rnd128(), 3, -1);
        $display("txn post_wait_abort: complete");

        // Reset during TX bit 60.
        run_txn("rst_tx", PT, KEY, CT, 0, 60);
        $display("txn rst_tx: reset at tx bit 60");
        run_txn("post_rst", rnd128(), rnd128(), rnd128(), 3, -1);
        $display("txn post_rst: complete");

        chk("scoreboard empty", 128'(exp_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_slave_port.md
Name: spi_slave_port

Overview:
- Slave end of the single-bit serial link that the team's Master block drives toward an AES core.
- Receives a 128-bit message then a 128-bit key on mosi while cs is high.
- Hands the message and key to an attached encryption or decryption core and waits for the core to finish.
- Returns the 128-bit result on miso, framed by a one-bit start marker. One instance sits in front of each of encryption_unit and decryption_unit.

Parameters:
- MSG_W, 128, message/result width in bits.
- KEY_W, 128, key width in bits (nk=4).
- CNT_W, 9, width of the bit counter; must satisfy 2^CNT_W > MSG_W+KEY_W.

Ports:
- clk  input  1  system clock; all sampling and driving on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- cs  input  1  chip select, active-high; frames one transaction.
- mosi  input  1  serial data from the master, MSB-first.
- miso  output  1  serial data to the master; idle 0.
- core_msg  output  MSG_W  message for the core; held stable from the core_start pulse until the core result is latched.
- core_key  output  KEY_W  key for the core; same stability rule as core_msg.
- core_start  output  1  one-cycle pulse requesting one core operation.
- core_result  input  MSG_W  core output; valid in the cycle core_done=1.
- core_done  input  1  one-cycle completion strobe from the core.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, miso=0, core_start=0, busy=0, core_msg=0, core_key=0, bit counter=0, tx shift register=0.
- States: IDLE, RX, START, WAIT, MARK, TX, DONE.
- IDLE:
  - miso=0.
  - On a cycle with cs=1, go to RX; mosi is already sampled as bit 0 in this cycle.
- RX:
  - Each cycle with cs=1, shift mosi into a 256-bit register MSB-first; counter increments.
  - Bits 0..127 form the message (bit 0 = message[127]); bits 128..255 form the key.
  - After bit 255, go to START.
- START:
  - core_msg/core_key are loaded from the register; core_start=1 for exactly this cycle.
  - Next state is WAIT.
- WAIT:
  - mosi is ignored.
  - On core_done=1, latch core_result into the tx shift register and go to MARK.
  - core_done in any other state is ignored.
- MARK: miso=1 for exactly one cycle (start marker), then go to TX.
- TX:
  - miso = tx[127] then shift left, once per cycle; 128 cycles, counter-tracked.
  - Next state is DONE.
- DONE:
  - miso=0.
  - Stay until cs=0, then go to IDLE. A new transaction requires cs to go low and then high again; holding cs high never restarts a transaction.
- Total latency, cs rise to first result bit on miso: 256 receive cycles + 1 (START) + core latency + 1 (MARK).
- Abort: cs=0 in RX, START, WAIT, MARK or TX returns to IDLE on the next edge.
  - Counter is cleared, miso=0, no core_start is issued.
  - A core_done arriving after an abort is discarded.
- core_done asserted in the same cycle as core_start is not possible by contract; the block does not check for it.
- Reset mid-operation: the asynchronous reset wins in any state; all outputs return to their reset values immediately.

Decomposition:
- Shared package (aes_pkg): MSG_W=128, KEY_W=128, the state encoding enum, and the marker bit value.
- Natural sub-module: spi_shift_reg, a parameterised width/direction shift register with parallel load. It is instantiated once for RX (serial-in, 256 bits) and once for TX (parallel-load, serial-out, 128 bits).

Test Plan:
- FIPS-197 vector: send msg 00112233445566778899aabbccddeeff then key 000102030405060708090a0b0c0d0e0f, with a stub core returning 69c4e0d86a7b0430d8cdb78070b4c55a after 12 cycles.
  - Required: core_start pulses once, 1 cycle after bit 255.
  - core_msg/core_key equal the sent values.
  - miso=1 marker appears 1 cycle after core_done, followed by 69c4e0d8...c55a MSB-first.
  - Then miso=0 and busy stays high until cs drops.
- Decrypt direction: same framing with msg 69c4e0d86a7b0430d8cdb78070b4c55a, stub returns 00112233445566778899aabbccddeeff -> bitstream matches exactly.
- Abort in RX: drop cs after 100 bits.
  - Required: next cycle busy=0 and miso=0; core_start never pulses.
  - A following full transaction completes correctly.
- Abort in WAIT: drop cs, then the stub asserts core_done 5 cycles later -> no marker on miso, state IDLE.
- cs held high after DONE for 50 cycles -> miso stays 0 and no second core_start; after cs low→high, a new transaction starts.
- rst asserted mid-TX (bit 60) -> miso=0, busy=0 and core_start=0 immediately, without waiting for a clock edge.
